// File: rtl/keyseq_pkg.sv
// Shared types and helpers for the key_sequencer button-code dialer.
// The FSM state list grows by WAIT_LOCK when KEYSEQ_LOCK_WAIT_EN is defined.
package keyseq_pkg;

  localparam logic [1:0] KEY_NONE = 2'b00;
  localparam logic [1:0] KEY_1    = 2'b01;
  localparam logic [1:0] KEY_2    = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_PRESS,
    S_GAP,
    S_STAR,
    S_STAR_GAP,
    S_WAIT_RESP,
    S_FINISH
`ifdef KEYSEQ_LOCK_WAIT_EN
    , S_WAIT_LOCK
`endif
  } state_t;

  // The timer is always loaded with (cycles - 1), so log2 of the largest
  // interval is enough bits.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/keyseq_timer.sv
// Loadable down-counter with a zero flag; shared by every timed state of
// the key_sequencer FSM.
module keyseq_timer
  import keyseq_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/key_sequencer.sv
// Replays a latched button code as timed press pulses to the lock, then
// checks for open. Define KEYSEQ_LOCK_WAIT_EN to wait for lock before pressing.
module key_sequencer
  import keyseq_pkg::*;
#(
  parameter int MAX_DIGITS  = 4,
  parameter int PRESS_CYC   = 1,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 8,
  localparam int LEN_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2*MAX_DIGITS-1:0] code,
  input  logic [LEN_W-1:0]        code_len,
  input  logic                    send_star,
  input  logic                    open,
  input  logic                    lock,
  output logic [1:0]              button_2_1,
  output logic                    button_star,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    err
);

  localparam int CNT_W = cnt_width(PRESS_CYC, GAP_CYC, TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] PRESS_LD   = CNT_W'(PRESS_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYC - 1);

  state_t                  state_q, state_d;
  logic [2*MAX_DIGITS-1:0] code_q, code_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        idx_q, idx_d;
  logic                    star_q, star_d;
  logic [1:0]              btn_q, btn_d;
  logic                    bstar_q, bstar_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic                    err_q, err_d;

  logic                    tmr_load;
  logic [CNT_W-1:0]        tmr_val;
  logic                    tmr_zero;
  logic                    bad_digit;
  logic                    begin_first;
  logic                    go_finish;
  logic [LEN_W-1:0]        nxt_idx;
  logic [1:0]              cur_digit;
  logic [1:0]              nxt_digit;

  keyseq_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

`ifndef KEYSEQ_LOCK_WAIT_EN
  logic unused_lock;
  assign unused_lock = lock;
`endif

  // Only digits below the requested length are validated.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (LEN_W'(i) < len_q &&
          (code_q[2*i +: 2] == KEY_NONE || code_q[2*i +: 2] == 2'b11)) begin
        bad_digit = 1'b1;
      end
    end
  end

  assign nxt_idx   = idx_q + LEN_W'(1);
  assign cur_digit = 2'(code_q >> {idx_q, 1'b0});
  assign nxt_digit = 2'(code_q >> {nxt_idx, 1'b0});

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    len_d       = len_q;
    idx_d       = idx_q;
    star_d      = star_q;
    btn_d       = KEY_NONE;
    bstar_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_d       = err_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    begin_first = 1'b0;
    go_finish   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          code_d  = code;
          len_d   = code_len;
          star_d  = send_star;
          idx_d   = '0;
          pass_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad_digit || len_q > LEN_W'(MAX_DIGITS)) begin
          err_d     = 1'b1;
          go_finish = 1'b1;
        end else if (len_q == '0 && !star_q) begin
          go_finish = 1'b1;
        end else begin
`ifdef KEYSEQ_LOCK_WAIT_EN
          state_d  = S_WAIT_LOCK;
          tmr_load = 1'b1;
          tmr_val  = TIMEOUT_LD;
`else
          begin_first = 1'b1;
`endif
        end
      end
`ifdef KEYSEQ_LOCK_WAIT_EN
      S_WAIT_LOCK: begin
        if (lock) begin
          begin_first = 1'b1;
        end else if (tmr_zero) begin
          err_d     = 1'b1;
          go_finish = 1'b1;
        end
      end
`endif
      S_PRESS: begin
        if (tmr_zero) begin
          state_d  = S_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end else begin
          btn_d = cur_digit;
        end
      end
      S_GAP: begin
        if (tmr_zero) begin
          if (nxt_idx < len_q) begin
            idx_d    = nxt_idx;
            btn_d    = nxt_digit;
            state_d  = S_PRESS;
            tmr_load = 1'b1;
            tmr_val  = PRESS_LD;
          end else if (star_q) begin
            bstar_d  = 1'b1;
            state_d  = S_STAR;
            tmr_load = 1'b1;
            tmr_val  = PRESS_LD;
          end else begin
            go_finish = 1'b1;
          end
        end
      end
      S_STAR: begin
        if (tmr_zero) begin
          state_d  = S_STAR_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end else begin
          bstar_d = 1'b1;
        end
      end
      // An early open during the post-star gap already counts as a pass.
      S_STAR_GAP: begin
        if (open) pass_d = 1'b1;
        if (tmr_zero) begin
          if (pass_q || open) begin
            go_finish = 1'b1;
          end else begin
            state_d  = S_WAIT_RESP;
            tmr_load = 1'b1;
            tmr_val  = TIMEOUT_LD;
          end
        end
      end
      S_WAIT_RESP: begin
        if (open) begin
          pass_d    = 1'b1;
          go_finish = 1'b1;
        end else if (tmr_zero) begin
          go_finish = 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (begin_first) begin
      tmr_load = 1'b1;
      tmr_val  = PRESS_LD;
      if (len_q == '0) begin
        bstar_d = 1'b1;
        state_d = S_STAR;
      end else begin
        btn_d   = cur_digit;
        state_d = S_PRESS;
      end
    end

    if (go_finish) begin
      state_d = S_FINISH;
      done_d  = 1'b1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      star_q  <= 1'b0;
      btn_q   <= KEY_NONE;
      bstar_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      star_q  <= star_d;
      btn_q   <= btn_d;
      bstar_q <= bstar_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  assign button_2_1  = btn_q;
  assign button_star = bstar_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err         = err_q;

endmodule

// File: tb/tb_key_sequencer.sv
// Self-checking bench for key_sequencer: directed and randomized sequences
// checked cycle by cycle against a timeline model built from the dialing rules.
module tb_key_sequencer;

  localparam int MAXD = 4;
  localparam int PC   = 1;
  localparam int GC   = 2;
  localparam int TO   = 8;
  localparam int NEVER = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] code;
  logic [2:0] code_len;
  logic       send_star;
  logic       open;
  logic       lock;
  logic [1:0] button_2_1;
  logic       button_star;
  logic       busy;
  logic       done;
  logic       pass;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  key_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .code        (code),
    .code_len    (code_len),
    .send_star   (send_star),
    .open        (open),
    .lock        (lock),
    .button_2_1  (button_2_1),
    .button_star (button_star),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the cycle in which start is high; outputs are sampled at the
  // falling edge of each later cycle, then open/start for that cycle are set.
  task automatic run_scenario(input string name, input logic [7:0] c, input int len,
                              input bit st, input int open_cyc, input int repulse_cyc,
                              input int rst_cyc);
    logic [1:0] exp_btn [64];
    bit         exp_star [64];
    bit         bad, lock_to, exp_pass, exp_err;
    int         pre, t, w, done_at, last;
    for (int i = 0; i < 64; i++) begin
      exp_btn[i]  = 2'b00;
      exp_star[i] = 1'b0;
    end
    bad = (len > MAXD);
    for (int i = 0; i < MAXD; i++)
      if (i < len && (c[2*i +: 2] == 2'b00 || c[2*i +: 2] == 2'b11)) bad = 1'b1;
    pre     = 0;
    lock_to = 1'b0;
`ifdef KEYSEQ_LOCK_WAIT_EN
    if (!bad && !(len == 0 && !st)) begin
      if (lock) pre = 1;
      else      lock_to = 1'b1;
    end
`endif
    exp_pass = 1'b0;
    exp_err  = 1'b0;
    if (bad) begin
      exp_err = 1'b1;
      done_at = 2;
    end else if (lock_to) begin
      exp_err = 1'b1;
      done_at = 2 + TO;
    end else begin
      t = 2 + pre;
      for (int d = 0; d < len; d++) begin
        for (int p = 0; p < PC; p++) exp_btn[t+p] = c[2*d +: 2];
        t = t + PC + GC;
      end
      if (st) begin
        for (int p = 0; p < PC; p++) exp_star[t+p] = 1'b1;
        w = t + PC + GC;
        if (open_cyc <= w - 1) begin
          exp_pass = 1'b1;
          done_at  = w;
        end else if (open_cyc <= w + TO - 1) begin
          exp_pass = 1'b1;
          done_at  = open_cyc + 1;
        end else begin
          done_at = w + TO;
        end
      end else begin
        done_at = t;
      end
    end
    if (repulse_cyc > done_at) repulse_cyc = done_at;
    last = (rst_cyc > 0) ? rst_cyc : done_at + 2;

    @(negedge clk);
    code      = c;
    code_len  = len[2:0];
    send_star = st;
    start     = 1'b1;
    open      = 1'b0;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      n_cmp++;
      if (button_2_1 !== exp_btn[k]) begin
        n_bad++;
        $display("[TB] FAIL %s cyc%0d button_2_1: got %b want %b", name, k, button_2_1, exp_btn[k]);
      end
      n_cmp++;
      if (button_star !== exp_star[k]) begin
        n_bad++;
        $display("[TB] FAIL %s cyc%0d button_star: got %b want %b", name, k, button_star, exp_star[k]);
      end
      n_cmp++;
      if (busy !== (k < done_at)) begin
        n_bad++;
        $display("[TB] FAIL %s cyc%0d busy: got %b want %b", name, k, busy, (k < done_at));
      end
      n_cmp++;
      if (done !== (k == done_at)) begin
        n_bad++;
        $display("[TB] FAIL %s cyc%0d done: got %b want %b", name, k, done, (k == done_at));
      end
      if (k == done_at || k == done_at + 1) begin
        n_cmp++;
        if (pass !== exp_pass) begin
          n_bad++;
          $display("[TB] FAIL %s cyc%0d pass: got %b want %b", name, k, pass, exp_pass);
        end
        n_cmp++;
        if (err !== exp_err) begin
          n_bad++;
          $display("[TB] FAIL %s cyc%0d err: got %b want %b", name, k, err, exp_err);
        end
      end
      start = (k == repulse_cyc);
      open  = (k >= open_cyc);
      if (k == rst_cyc) rst = 1'b1;
    end
    if (rst_cyc > 0) begin
      @(negedge clk);
      n_cmp++;
      if ({button_2_1, button_star, busy, done, pass, err} !== 7'b0) begin
        n_bad++;
        $display("[TB] FAIL %s after_rst outputs: got %b want 0000000", name,
                 {button_2_1, button_star, busy, done, pass, err});
      end
      rst = 1'b0;
    end
    start = 1'b0;
    open  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; code = '0; code_len = '0; send_star = 1'b0;
    open = 1'b0; lock = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (button_2_1 !== 2'b00) begin n_bad++; $display("[TB] FAIL reset button_2_1: got %b want 00", button_2_1); end
    n_cmp++;
    if (button_star !== 1'b0) begin n_bad++; $display("[TB] FAIL reset button_star: got %b want 0", button_star); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset done: got %b want 0", done); end
    n_cmp++;
    if ({pass, err} !== 2'b00) begin n_bad++; $display("[TB] FAIL reset pass_err: got %b want 00", {pass, err}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    // code {10,01}: digit 0 = 01, digit 1 = 10; star at cycle 8
    run_scenario("open_after_star", 8'b0000_1001, 2, 1'b1, 9, 0, 0);
    run_scenario("open_never", 8'b0000_1001, 2, 1'b1, NEVER, 0, 0);
    run_scenario("open_in_wait", 8'b0000_1001, 2, 1'b1, 14, 0, 0);
    run_scenario("bad_digit", 8'b0000_1101, 2, 1'b1, NEVER, 0, 0);
    run_scenario("len_too_big", 8'b1010_1010, 5, 1'b0, NEVER, 0, 0);
    run_scenario("full_len", 8'b0110_1001, 4, 1'b0, NEVER, 0, 0);
  endtask

  task automatic test_len_zero();
    run_scenario("len0_star", 8'h00, 0, 1'b1, 4, 0, 0);
    run_scenario("len0_star_to", 8'h00, 0, 1'b1, NEVER, 0, 0);
    run_scenario("len0_nostar", 8'h00, 0, 1'b0, NEVER, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_scenario("repulse_busy", 8'b0000_1001, 2, 1'b1, 10, 3, 0);
    run_scenario("start_at_finish", 8'b0000_0110, 2, 1'b0, NEVER, 99, 0);
    run_scenario("rst_in_gap", 8'b0000_1001, 2, 1'b0, NEVER, 3, 6);
    run_scenario("after_rst", 8'b0000_1001, 2, 1'b1, 9, 0, 0);
  endtask

  task automatic test_random();
    logic [7:0] c;
    int len, s, oc, rp;
    bit st;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < MAXD; i++) begin
        if ($urandom_range(0, 9) == 0) c[2*i +: 2] = 2'($urandom_range(0, 3));
        else c[2*i +: 2] = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      end
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      st  = ($urandom_range(0, 3) != 0);
      s   = 2 + 3 * len;
      oc  = ($urandom_range(0, 3) == 0) ? NEVER : s + $urandom_range(1, 14);
      rp  = ($urandom_range(0, 1) != 0) ? $urandom_range(2, 30) : 0;
      run_scenario("random", c, len, st, oc, rp, 0);
    end
  endtask

`ifdef KEYSEQ_LOCK_WAIT_EN
  task automatic test_lock_wait();
    lock = 1'b0;
    run_scenario("lock_low", 8'b0000_1001, 2, 1'b1, NEVER, 0, 0);
    lock = 1'b1;
    run_scenario("lock_high", 8'b0000_1001, 2, 1'b1, 10, 0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_len_zero();
    test_back_to_back();
    test_random();
`ifdef KEYSEQ_LOCK_WAIT_EN
    test_lock_wait();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
